// File: rtl/pgm_sched_if.sv
// PGM replay datapath bundle: RAM read port toward the packet RAM plus the packet output stream.
interface pgm_sched_if #(
  parameter int ADDR_W = 7
);
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [143:0]      ram_rdata;
  logic              in_alf;
  logic [133:0]      out_data;
  logic              out_data_wr;
  logic              out_valid;
  logic              out_valid_wr;

  modport master (
    output ram_rd_en, ram_rd_addr, out_data, out_data_wr, out_valid, out_valid_wr,
    input  ram_rdata, in_alf
  );

  modport slave (
    input  ram_rd_en, ram_rd_addr, out_data, out_data_wr, out_valid, out_valid_wr,
    output ram_rdata, in_alf
  );
endinterface

// File: rtl/pgm_sched.sv
// Replays the stored template packet cfg_pkt_num times (0 = until stop) with cfg_gap idle
// cycles between copies; 1-cycle read-to-output latency, reads paused while in_alf is high.
module pgm_sched #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 32,
  parameter int GAP_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] cfg_last_addr,
  input  logic [CNT_W-1:0]  cfg_pkt_num,
  input  logic [GAP_W-1:0]  cfg_gap,
  output logic              busy,
  output logic [CNT_W-1:0]  sent_cnt,
  pgm_sched_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              start_d;
  logic              stop_pend;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last_q;
  logic [CNT_W-1:0]  num_q;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic              rd_en_d1;
  logic              last_d1;

  logic launch;
  logic rd_fire;
  logic rd_last;
  logic run_end;
  logic gap_end;
  logic unused_rdata;

  assign unused_rdata = ^bus.ram_rdata[143:134];

  always_comb begin
    state_nxt = state;
    // a launch is refused while the previous run's final beat is still draining
    launch    = start & ~start_d & (state == IDLE) & ~rd_en_d1;
    rd_fire   = (state == READ) & ~bus.in_alf;
    rd_last   = rd_fire & (addr == last_q);
    // rd_cnt counts copies whose last read was issued; sent_cnt lags it by the pipeline
    run_end   = stop | stop_pend | ((num_q != '0) && (rd_cnt + 1'b1 == num_q));
    gap_end   = (gap_cnt == gap_q - 1'b1);
    case (state)
      IDLE: begin
        if (launch) state_nxt = READ;
      end
      READ: begin
        if (rd_last) begin
          if (run_end)          state_nxt = IDLE;
          else if (gap_q == '0) state_nxt = READ;
          else                  state_nxt = GAP;
        end
      end
      GAP: begin
        if (stop | stop_pend) state_nxt = IDLE;
        else if (gap_end)     state_nxt = READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      start_d   <= 1'b0;
      stop_pend <= 1'b0;
      addr      <= '0;
      last_q    <= '0;
      num_q     <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      rd_cnt    <= '0;
      rd_en_d1  <= 1'b0;
      last_d1   <= 1'b0;
      sent_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      start_d  <= start;
      rd_en_d1 <= rd_fire;
      last_d1  <= rd_last;

      if (launch) begin
        last_q    <= cfg_last_addr;
        num_q     <= cfg_pkt_num;
        gap_q     <= cfg_gap;
        stop_pend <= stop;
        addr      <= '0;
        rd_cnt    <= '0;
        sent_cnt  <= '0;
      end else begin
        // stop is remembered so a short pulse still ends the run at a copy boundary
        stop_pend <= (state != IDLE) & (stop_pend | stop);
        if (rd_fire) addr <= rd_last ? '0 : addr + 1'b1;
        if (rd_last) rd_cnt <= rd_cnt + 1'b1;
        if (rd_en_d1 && last_d1) sent_cnt <= sent_cnt + 1'b1;
      end

      if (state == GAP && !gap_end && !(stop | stop_pend)) gap_cnt <= gap_cnt + 1'b1;
      else                                                   gap_cnt <= '0;
    end
  end

  assign bus.ram_rd_en    = rd_fire;
  assign bus.ram_rd_addr  = rd_fire ? addr : '0;
  assign bus.out_data_wr  = rd_en_d1;
  assign bus.out_data     = rd_en_d1 ? bus.ram_rdata[133:0] : '0;
  assign bus.out_valid_wr = rd_en_d1 & last_d1;
  assign bus.out_valid    = rd_en_d1 & last_d1;
  assign busy             = (state != IDLE) | rd_en_d1;

endmodule

// File: tb/tb_pgm_sched.sv
// Randomized replay runs checked against an index-arithmetic model of the expected beat stream.
module tb_pgm_sched;
  typedef logic [133:0] v_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [6:0]  cfg_last_addr;
  logic [31:0] cfg_pkt_num;
  logic [15:0] cfg_gap;
  logic        busy;
  logic [31:0] sent_cnt;

  pgm_sched_if #(.ADDR_W(7)) bus ();

  pgm_sched #(.ADDR_W(7), .CNT_W(32), .GAP_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .cfg_last_addr (cfg_last_addr),
    .cfg_pkt_num   (cfg_pkt_num),
    .cfg_gap       (cfg_gap),
    .busy          (busy),
    .sent_cnt      (sent_cnt),
    .bus           (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [143:0] mem [128];

  // run plan, written only by the stimulus process
  int p_last  = 0;
  int p_total = 0;
  int p_gap   = 0;
  bit p_alf   = 0;
  int run_id  = 0;
  bit mon_en  = 0;

  // monitor state, written only by the monitor
  int seen_id    = 0;
  int beats_seen = 0;
  int prev_cyc   = 0;
  int prev_w     = 0;
  bit have_prev  = 0;
  bit prev_alf   = 0;

  task automatic chk(input string tag, input v_t act, input v_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // packet RAM: data one cycle after the read strobe, garbage otherwise
  always @(posedge clk) begin
    if (bus.ram_rd_en) bus.ram_rdata <= mem[bus.ram_rd_addr];
    else               bus.ram_rdata <= {16'hdead, $urandom(), $urandom(), $urandom(), $urandom()};
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      int w;
      if (run_id != seen_id) begin
        seen_id    = run_id;
        beats_seen = 0;
        have_prev  = 0;
      end
      if (bus.in_alf) chk("rd_during_alf", v_t'(bus.ram_rd_en), v_t'(0));
      if (bus.out_valid_wr) chk("valid_without_data", v_t'(bus.out_data_wr), v_t'(1));
      if (!bus.out_data_wr) chk("idle_data", bus.out_data, v_t'(0));
      if (bus.out_data_wr) begin
        w = beats_seen % (p_last + 1);
        chk("extra_beat", v_t'(beats_seen < p_total), v_t'(1));
        chk("data", bus.out_data, mem[w][133:0]);
        chk("valid_wr", v_t'(bus.out_valid_wr), v_t'(w == p_last));
        chk("valid", v_t'(bus.out_valid), v_t'(w == p_last));
        chk("sent_cnt", v_t'(sent_cnt), v_t'(beats_seen / (p_last + 1)));
        chk("alf_slip", v_t'(prev_alf), v_t'(0));
        if (have_prev && !p_alf)
          chk("spacing", v_t'(cyc - prev_cyc), v_t'((prev_w == p_last) ? p_gap + 1 : 1));
        have_prev  = 1;
        prev_cyc   = cyc;
        prev_w     = w;
        beats_seen = beats_seen + 1;
      end
      prev_alf = bus.in_alf;
    end
  end

  task automatic run(input int last, input int num, input int gap, input bit alf,
                     input int stop_after, input bit stop_l, input bit hold);
    int ncopies;
    int cycles;
    ncopies = stop_l ? 1 : ((num != 0) ? num : stop_after);
    p_last  = last;
    p_total = ncopies * (last + 1);
    p_gap   = gap;
    p_alf   = alf;
    run_id  = run_id + 1;
    @(posedge clk); #1;
    cfg_last_addr = 7'(last);
    cfg_pkt_num   = 32'(num);
    cfg_gap       = 16'(gap);
    stop          = stop_l;
    start         = 1'b1;
    @(posedge clk); #1;
    chk("busy_launch", v_t'(busy), v_t'(1));
    if (!hold) start = 1'b0;
    cycles = 0;
    while (busy && cycles < 5000) begin
      bus.in_alf = alf ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (stop_after > 0 && beats_seen >= (stop_after - 1) * (last + 1) + 1) stop = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    bus.in_alf = 1'b0;
    chk("run_timeout", v_t'(busy), v_t'(0));
    chk("busy_drop", v_t'(cyc), v_t'(prev_cyc + 1));
    chk("beats_total", v_t'(beats_seen), v_t'(p_total));
    chk("sent_cnt_end", v_t'(sent_cnt), v_t'(ncopies));
    stop = 1'b0;
    if (hold) begin
      repeat (4) @(posedge clk);
      #1;
      chk("no_relaunch", v_t'(busy), v_t'(0));
      start = 1'b0;
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [159:0] tmp;
    int n;
    for (int i = 0; i < 128; i++) begin
      tmp    = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      mem[i] = tmp[143:0];
    end
    rst_n         = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    cfg_last_addr = '0;
    cfg_pkt_num   = '0;
    cfg_gap       = '0;
    bus.in_alf    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", v_t'(bus.ram_rd_en), v_t'(0));
    chk("rst_rd_addr", v_t'(bus.ram_rd_addr), v_t'(0));
    chk("rst_data_wr", v_t'(bus.out_data_wr), v_t'(0));
    chk("rst_data", bus.out_data, v_t'(0));
    chk("rst_valid", v_t'(bus.out_valid), v_t'(0));
    chk("rst_valid_wr", v_t'(bus.out_valid_wr), v_t'(0));
    chk("rst_busy", v_t'(busy), v_t'(0));
    chk("rst_sent_cnt", v_t'(sent_cnt), v_t'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    run(3, 2, 0, 0, 0, 0, 0);   // contiguous back-to-back copies
    run(1, 3, 5, 0, 0, 0, 0);   // five idle cycles between copies
    run(7, 1, 0, 1, 0, 0, 0);   // random almost-full pauses
    run(4, 0, 2, 0, 5, 0, 0);   // free-running, stopped mid fifth copy
    run(0, 4, 0, 0, 0, 0, 0);   // single-word copies
    run(3, 5, 1, 0, 0, 1, 0);   // stop together with launch
    run(2, 2, 1, 0, 0, 0, 1);   // start held high across the run
    run(127, 1, 0, 0, 0, 0, 0); // full RAM depth
    for (int k = 0; k < 10; k++)
      run($urandom_range(0, 15), $urandom_range(1, 4), $urandom_range(0, 6),
          1'($urandom_range(0, 1)), 0, 0, 0);
    run($urandom_range(2, 9), 0, $urandom_range(0, 3), 0, $urandom_range(2, 4), 0, 0);

    // asynchronous reset during the second copy
    mon_en = 1'b0;
    @(posedge clk); #1;
    cfg_last_addr = 7'd3;
    cfg_pkt_num   = 32'd3;
    cfg_gap       = 16'd0;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!bus.out_valid_wr && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_first_copy", v_t'(bus.out_valid_wr), v_t'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_data_wr", v_t'(bus.out_data_wr), v_t'(0));
    chk("t6_data", bus.out_data, v_t'(0));
    chk("t6_valid_wr", v_t'(bus.out_valid_wr), v_t'(0));
    chk("t6_rd_en", v_t'(bus.ram_rd_en), v_t'(0));
    chk("t6_busy", v_t'(busy), v_t'(0));
    chk("t6_sent_cnt", v_t'(sent_cnt), v_t'(0));
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    run(3, 2, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
